clk_period_meter: RTL
=====================

Name: clk_period_meter

Overview:
- Measures an external or derived slow clock (for example the 25 MHz pixel clock) from inside the clk_100mhz domain.
- Reports period and high time in clk_100mhz cycles, flags a missing clock, and asserts lock once the period matches an expected value repeatedly.
- Sits beside clock dividers as their self-check and status monitor.

Parameters:
- CNT_W, 16, width of the period, high-time and timeout counters.
- TIMEOUT, 1024, clk_100mhz cycles without a rising edge before timeout is declared; must satisfy 2 <= TIMEOUT <= 2**CNT_W-1.
- EXPECT, 4, expected period in clk_100mhz cycles.
- TOL, 0, allowed absolute deviation from EXPECT.
- LOCK_CNT, 4, consecutive in-tolerance periods required for lock; must be >= 1.

Ports:
- clk_100mhz  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- clk_in  input  1  monitored clock, asynchronous to clk_100mhz, treated as data.
- period  output  CNT_W  last measured period in clk_100mhz cycles.
- high_time  output  CNT_W  clk_100mhz cycles clk_in was high within that period.
- period_valid  output  1  one-cycle pulse when period/high_time update.
- timeout  output  1  sticky flag: no clk_in edge for TIMEOUT cycles.
- locked  output  1  period stable within tolerance.

Behaviour:
- Reset (async, rst_n low): all outputs 0, all counters 0, state IDLE. Release takes effect on the next clk_100mhz edge.
- Synchronizer and edge detect:
  - clk_in passes two flops (s1, s2); a third flop s3 delays s2.
  - Rising edge is rise = s2 & ~s3.
  - Latency from clk_in rising to rise is 2–3 clk_100mhz cycles.
- Counters:
  - cnt counts cycles since the last rise: cleared to 0 on rise, otherwise incremented, saturating at TIMEOUT.
  - hi_cnt is set to 1 on rise, otherwise incremented when s2 is high, saturating at all-ones.
- States:
  - IDLE (no reference edge yet): on rise go to MEASURE; no period_valid; timeout cleared.
  - MEASURE, on rise:
    - period <= cnt+1 and high_time <= hi_cnt, with period_valid pulsed the following cycle, registered alongside the data.
    - Stay in MEASURE.
  - MEASURE with no rise and cnt == TIMEOUT-1: timeout <= 1, locked <= 0, match counter <= 0, go to IDLE. period and high_time hold their last values.
- Simultaneous rise and timeout threshold in the same cycle: the rise wins and no timeout is declared.
- Lock, evaluated on each measured period p:
  - match = (p >= EXPECT-TOL) && (p <= EXPECT+TOL), computed in CNT_W+1 bits so that no underflow or overflow occurs.
  - On match, the match counter increments, saturating at LOCK_CNT; locked <= 1 when it reaches LOCK_CNT.
  - On a mismatch, the match counter <= 0 and locked <= 0 in the same cycle period_valid pulses.
- The first period after reset or after a timeout is never measured; its rise only arms MEASURE.
- clk_in stuck high or stuck low: produces a timeout. high_time saturates rather than wrapping.
- Reset asserted mid-measurement: everything returns to the reset values immediately.

Decomposition:
- Package clk_meter_pkg: state encoding (IDLE, MEASURE) and the width-safe tolerance compare as a function.
- Sub-module sync_edge_detect (2-flop synchronizer plus rise pulse, async active-low reset). It is reusable for other async inputs.

Test Plan:
- clk_in driven by a /4 divider (toggles every 2 cycles) with EXPECT=4, TOL=0, LOCK_CNT=4:
  - first rise gives no valid;
  - each later rise gives period=4, high_time=2, period_valid one cycle;
  - locked rises on the 4th valid.
- Lock established, then one period stretched to 6 cycles: period=6, locked drops in the same cycle as that period_valid; locked regains after 4 further 4-cycle periods.
- clk_in held low after lock with TIMEOUT=1024: exactly 1024 cycles after the last rise, timeout=1 and locked=0; period stays 4; the next rise clears timeout without a valid pulse.
- clk_in held high: timeout asserts and high_time is unchanged; after release, measurement resumes normally.
- Rise arriving on the exact cycle cnt == TIMEOUT-1 (small TIMEOUT=8, period 8): period=8 reported and timeout stays 0.
- rst_n pulsed low for 3 cycles mid-period while locked: all outputs 0 asynchronously; after release the first rise gives no valid and lock needs 4 new matches.

Source files
------------

// File: rtl/clk_meter_pkg.sv
// Shared definitions for the clock period meter: FSM state encoding and a
// width-safe tolerance compare used to decide whether a measured period
// counts towards lock.
package clk_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

    // True when p lies in [exp_val - tol, exp_val + tol]. The lower bound is
    // rewritten as p + tol >= exp_val so nothing is ever subtracted, and all
    // sums are formed one bit wider than the operands, so a small expected
    // value with a large tolerance (or a large expected value plus tolerance)
    // can neither underflow nor overflow. Counter widths up to 32 bits are
    // supported.
    function automatic logic in_tolerance(
        input logic [31:0] p,
        input logic [31:0] exp_val,
        input logic [31:0] tol
    );
        logic [32:0] p_ext;
        logic [32:0] e_ext;
        logic [32:0] t_ext;
        p_ext = {1'b0, p};
        e_ext = {1'b0, exp_val};
        t_ext = {1'b0, tol};
        return ((p_ext + t_ext) >= e_ext) && (p_ext <= (e_ext + t_ext));
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, plus a one-cycle pulse on
// each synchronized rising edge. A third flop delays the synchronized level so
// the edge compare never looks at a possibly metastable stage.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronizer chain followed by the edge-history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period and high time of a slow, asynchronous clock in units of
// clk_100mhz cycles, flags a missing clock, and reports lock once the period
// has matched the expected value LOCK_CNT times in a row.
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 1024,
    parameter int EXPECT   = 4,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk_100mhz,
    input  logic             rst_n,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             timeout,
    output logic             locked
);

    localparam int LOCK_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]  TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [LOCK_W-1:0] LOCK_C     = LOCK_W'(LOCK_CNT);

    meter_state_t      state;
    meter_state_t      next_state;

    logic              clk_level;
    logic              rise;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  hi_cnt;
    logic [CNT_W-1:0]  period_next;

    logic [LOCK_W-1:0] match_cnt;
    logic [LOCK_W-1:0] match_next;
    logic              period_match;

    logic              capture;
    logic              fire_timeout;
    logic              arm;

    sync_edge_detect u_sync (
        .clk   (clk_100mhz),
        .rst_n (rst_n),
        .din   (clk_in),
        .level (clk_level),
        .rise  (rise)
    );

    // The rise cycle itself is the first cycle of the new period, so the
    // period just ending is the count so far plus one.
    assign period_next  = cnt + 1'b1;
    assign period_match = in_tolerance(32'(period_next), 32'(EXPECT), 32'(TOL));

    // Next value of the consecutive-match counter if this period matches.
    always_comb begin
        match_next = match_cnt;
        if (match_cnt != LOCK_C) begin
            match_next = match_cnt + 1'b1;
        end
    end

    // Next-state logic: IDLE waits for a reference edge, MEASURE captures on
    // every rise and falls back to IDLE when the clock goes missing. A rise
    // always beats the timeout threshold when both land in the same cycle.
    always_comb begin
        next_state   = state;
        capture      = 1'b0;
        fire_timeout = 1'b0;
        arm          = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    arm        = 1'b1;
                    next_state = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    capture = 1'b1;
                end else if (cnt == TIMEOUT_M1) begin
                    fire_timeout = 1'b1;
                    next_state   = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Cycles since the last rise, held at TIMEOUT while no clock is present.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= '0;
        end else if (cnt != TIMEOUT_C) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Cycles the synchronized clock has been high since the last rise; the
    // rise cycle counts as the first high cycle. Saturates instead of wrapping.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt <= '0;
        end else if (rise) begin
            hi_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (clk_level && (hi_cnt != '1)) begin
            hi_cnt <= hi_cnt + 1'b1;
        end
    end

    // Measurement results with their valid strobe, and the sticky timeout
    // flag that only a fresh reference edge clears.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= capture;
            if (capture) begin
                period    <= period_next;
                high_time <= hi_cnt;
            end
            if (fire_timeout) begin
                timeout <= 1'b1;
            end else if (arm) begin
                timeout <= 1'b0;
            end
        end
    end

    // Lock tracking: consecutive in-tolerance periods build up to lock, any
    // miss or a missing clock drops it immediately.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
            locked    <= 1'b0;
        end else if (fire_timeout) begin
            match_cnt <= '0;
            locked    <= 1'b0;
        end else if (capture) begin
            if (period_match) begin
                match_cnt <= match_next;
                locked    <= (match_next == LOCK_C);
            end else begin
                match_cnt <= '0;
                locked    <= 1'b0;
            end
        end
    end

endmodule
